chip8_reg_mem_transfer: RTL
===========================

// Module: chip8_reg_mem_transfer
// PURPOSE
//  Bulk mover between the 16x8 V-register file and main memory for FX55 (store V0..VX to [I..I+X]) and FX65 (load V0..VX from [I..I+X]).
//  Drives the register file's write port and read port 1, plus one RAM port.
//  The CPU decoder starts it, then stalls until done. Optional I post-increment (original COSMAC quirk).
// PARAMETERS
//  ADDR_W       12  memory address width; all address arithmetic is mod 2**ADDR_W
//  QUIRK_INC_I  1   1: update I <= I+X+1 at completion; 0: I untouched (index_we never asserted)
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  start        in   1       one-cycle request, sampled only in IDLE
//  dir_load     in   1       0 = store regs->mem (FX55), 1 = load mem->regs (FX65)
//  x            in   4       last register index X, inclusive
//  index_i      in   ADDR_W  current I; sampled with start
//  busy         out  1       high from the cycle after start until done
//  done         out  1       one-cycle pulse at completion
//  index_we     out  1       pulses with done when QUIRK_INC_I=1
//  index_new    out  ADDR_W  I+X+1 mod 2**ADDR_W; valid while index_we=1
//  rf_sel_out   out  4       register-file read select (port 1)
//  rf_rdata     in   8       register-file output1_data (registered, 1-cycle latency)
//  rf_we        out  1       register-file write_enable
//  rf_sel_in    out  4       register-file write select
//  rf_wdata     out  8       register-file write data
//  mem_addr     out  ADDR_W  memory address
//  mem_we       out  1       memory write strobe
//  mem_wdata    out  8       memory write data
//  mem_rdata    in   8       memory read data (sync RAM, 1-cycle latency)
// BEHAVIOUR
//  - Reset: state IDLE. busy, done, index_we, rf_we and mem_we = 0. All select/address/data outputs = 0.
//  - On start in IDLE: latch dir_load, x, index_i as base; count k <= 0.
//  - Store path: IDLE -> S_RD -> S_WR -> S_RD ... -> FIN.
//    S_RD: rf_sel_out=k.
//    S_WR: mem_addr=base+k, mem_wdata=rf_rdata, mem_we=1. If k==x -> FIN, else k++ -> S_RD.
//  - Load path: IDLE -> L_RD -> L_WR -> L_RD ... -> FIN.
//    L_RD: mem_addr=base+k, mem_we=0.
//    L_WR: rf_sel_in=k, rf_wdata=mem_rdata, rf_we=1. If k==x -> FIN, else k++ -> L_RD.
//  - FIN: done=1 for one cycle; index_we=QUIRK_INC_I; index_new=base+x+1. Next state IDLE; busy=0 in FIN.
//  - Timing: start at cycle t; first RD state at t+1; FIN at t+1+2*(x+1). Total latency 2x+3 cycles start->done.
//  - Exactly x+1 write strobes per operation, never more; strobes are single-cycle and not back-to-back.
//  - Address wrap: base+k and base+x+1 wrap mod 2**ADDR_W (e.g. I=0xFFE, x=3 -> 0xFFE,0xFFF,0x000,0x001; I_new=0x002).
//  - x=0: a single transfer. x=F includes VF.
//  - start while busy or in FIN: ignored, no queuing.
//  - Reset mid-operation: immediate return to IDLE; strobes drop in the same cycle; no done; partial transfers stand.
//  - Write strobes are 0 in every state except S_WR (mem_we) and L_WR (rf_we). rf_sel_out/mem_addr may idle at any value.
// STRUCTURE
//  - Shared package chip8_pkg:
//    ADDR_W default, NUM_REGS=16, REG_IDX_W=4;
//    state enum {IDLE, S_RD, S_WR, L_RD, L_WR, FIN}.
//  - Single flat module: FSM + 4-bit counter + latched base/x/dir.
//  - Natural sub-module: none; the register file is instantiated beside it by the CPU top.
// TESTING
//  - Bench pairs the DUT with the real register file and a 4 KiB sync RAM model.
//  1. Store: V0..V3 = 11,22,33,44; start dir_load=0 x=3 I=0x300
//     -> mem[0x300..0x303]=11,22,33,44; mem[0x304] untouched;
//     -> done exactly 9 cycles after start; index_new=0x304.
//  2. Load: mem[0x200..0x20F]=0xA0..0xAF; start dir_load=1 x=F I=0x200
//     -> V0..VF=0xA0..0xAF; exactly 16 rf_we pulses; done at cycle 33.
//  3. Wrap: I=0xFFE x=3 store -> writes at 0xFFE,0xFFF,0x000,0x001; index_new=0x002.
//  4. QUIRK_INC_I=0, x=0 load from 0x050 -> V0=mem[0x050]; V1 unchanged; index_we never 1; done at cycle 3.
//  5. Reset asserted in the 2nd S_WR of an x=5 store
//     -> mem_we low that cycle; only byte 0 written; no done; busy=0 next cycle.
//     -> A subsequent start runs normally.
//  6. start pulses every cycle during a load x=2
//     -> ignored; one done only; rf_we count=3.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core definitions: default widths and the register/memory
// transfer state encoding.
package chip8_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 12;
    localparam int unsigned NUM_REGS       = 16;
    localparam int unsigned REG_IDX_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        S_RD,
        S_WR,
        L_RD,
        L_WR,
        FIN
    } xfer_state_e;

endpackage

// File: rtl/chip8_reg_mem_transfer.sv
// FX55/FX65 bulk mover: copies V0..VX to/from memory starting at I,
// alternating a read cycle and a write cycle per byte.
module chip8_reg_mem_transfer
    import chip8_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter bit          QUIRK_INC_I = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dir_load,
    input  logic [REG_IDX_W-1:0] x,
    input  logic [ADDR_W-1:0]    index_i,
    output logic                 busy,
    output logic                 done,
    output logic                 index_we,
    output logic [ADDR_W-1:0]    index_new,
    output logic [REG_IDX_W-1:0] rf_sel_out,
    input  logic [7:0]           rf_rdata,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_sel_in,
    output logic [7:0]           rf_wdata,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    xfer_state_e          state_q, state_d;
    logic [REG_IDX_W-1:0] k_q, k_d;
    logic [REG_IDX_W-1:0] x_q, x_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [ADDR_W-1:0]    addr_k;
    logic                 last;

    assign addr_k = base_q + ADDR_W'(k_q);
    assign last   = (k_q == x_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            base_q  <= base_d;
        end
    end

    // Strobes are gated by reset so they drop in the very cycle reset is
    // raised, even though the state register only clears at the next edge.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        x_d        = x_q;
        base_d     = base_q;
        busy       = 1'b0;
        done       = 1'b0;
        index_we   = 1'b0;
        index_new  = '0;
        rf_sel_out = '0;
        rf_we      = 1'b0;
        rf_sel_in  = '0;
        rf_wdata   = '0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = index_i;
                    x_d     = x;
                    k_d     = '0;
                    state_d = dir_load ? L_RD : S_RD;
                end
            end
            S_RD: begin
                busy       = 1'b1;
                rf_sel_out = k_q;
                state_d    = S_WR;
            end
            S_WR: begin
                busy       = 1'b1;
                rf_sel_out = k_q;
                mem_addr   = addr_k;
                mem_wdata  = rf_rdata;
                mem_we     = ~reset;
                if (last) begin
                    state_d = FIN;
                end else begin
                    k_d     = k_q + REG_IDX_W'(1);
                    state_d = S_RD;
                end
            end
            L_RD: begin
                busy     = 1'b1;
                mem_addr = addr_k;
                state_d  = L_WR;
            end
            L_WR: begin
                busy      = 1'b1;
                mem_addr  = addr_k;
                rf_sel_in = k_q;
                rf_wdata  = mem_rdata;
                rf_we     = ~reset;
                if (last) begin
                    state_d = FIN;
                end else begin
                    k_d     = k_q + REG_IDX_W'(1);
                    state_d = L_RD;
                end
            end
            FIN: begin
                done      = ~reset;
                index_we  = QUIRK_INC_I & ~reset;
                index_new = base_q + ADDR_W'(x_q) + ADDR_W'(1);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
